// File: rtl/credit_link_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : credit_link_transmitter
// Brief    : Serializes whole packets onto a credit-flow-controlled link.
// Revision : 1.0
// ============================================================================
module credit_link_transmitter #(
  parameter  int FLIT_WIDTH   = 32,
  parameter  int PACKET_FLITS = 5,
  parameter  int BUFFER_DEPTH = 8,
  localparam int CW           = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [FLIT_WIDTH*PACKET_FLITS-1:0] packet_din,
  input  logic                               packet_valid_din,
  output logic                               packet_ready_dout,
  output logic [FLIT_WIDTH-1:0]              flit_dout,
  output logic                               flit_valid_dout,
  input  logic                               credit_din,
  output logic [CW-1:0]                      credit_count_dout,
  output logic                               busy_dout,
  output logic                               credit_overflow_dout,
  output logic [31:0]                        packet_count_dout
);

  localparam int IW = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [IW-1:0] LAST_IDX     = IW'(PACKET_FLITS - 1);
  localparam logic [CW-1:0] FULL_CREDITS = CW'(BUFFER_DEPTH);

  logic [0:0]                          state_q, state_d;
  logic [FLIT_WIDTH*PACKET_FLITS-1:0]  pkt_q, pkt_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic [FLIT_WIDTH-1:0]               flit_q, flit_d;
  logic                                valid_q, valid_d;
  logic [CW-1:0]                       credit_q, credit_d;
  logic                                overflow_q, overflow_d;
  logic [31:0]                         pkt_cnt_q, pkt_cnt_d;
  logic                                send;

  logic [FLIT_WIDTH-1:0] flits [PACKET_FLITS];

  generate
    for (genvar k = 0; k < PACKET_FLITS; k++) begin : g_flits
      assign flits[k] = pkt_q[k*FLIT_WIDTH +: FLIT_WIDTH];
    end
  endgenerate

  // Only the registered count gates a send; a credit arriving this cycle is usable next cycle.
  assign send = (state_q == SEND) && (credit_q != '0);

  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    idx_d      = idx_q;
    flit_d     = flit_q;
    valid_d    = 1'b0;
    credit_d   = credit_q;
    overflow_d = overflow_q;
    pkt_cnt_d  = pkt_cnt_q;

    case (state_q)
      IDLE: begin
        if (packet_valid_din) begin
          pkt_d   = packet_din;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      default: begin
        if (send) begin
          flit_d  = flits[idx_q];
          valid_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            state_d   = IDLE;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
    endcase

    if (send && !credit_din) begin
      credit_d = credit_q - CW'(1);
    end else if (!send && credit_din) begin
      if (credit_q == FULL_CREDITS) begin
        overflow_d = 1'b1;
      end else begin
        credit_d = credit_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      idx_q      <= '0;
      flit_q     <= '0;
      valid_q    <= 1'b0;
      credit_q   <= FULL_CREDITS;
      overflow_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      idx_q      <= idx_d;
      flit_q     <= flit_d;
      valid_q    <= valid_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign packet_ready_dout    = (state_q == IDLE);
  assign busy_dout            = (state_q == SEND);
  assign flit_dout            = flit_q;
  assign flit_valid_dout      = valid_q;
  assign credit_count_dout    = credit_q;
  assign credit_overflow_dout = overflow_q;
  assign packet_count_dout    = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_credit_link_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_credit_link_transmitter
// Brief    : Directed self-checking bench for credit_link_transmitter.
// Revision : 1.0
// ============================================================================
module tb_credit_link_transmitter;

  localparam int FW = 32;
  localparam int PF = 5;
  localparam int BD = 8;
  localparam int CW = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [FW*PF-1:0]   packet_din = '0;
  logic               packet_valid_din = 1'b0;
  logic               packet_ready_dout;
  logic [FW-1:0]      flit_dout;
  logic               flit_valid_dout;
  logic               credit_din = 1'b0;
  logic [CW-1:0]      credit_count_dout;
  logic               busy_dout;
  logic               credit_overflow_dout;
  logic [31:0]        packet_count_dout;

  int errors = 0;
  int checks = 0;

  logic [FW-1:0] flits_a [PF];
  logic [FW-1:0] flits_b [PF];
  logic [FW*PF-1:0] pkt_a;
  logic [FW*PF-1:0] pkt_b;

  credit_link_transmitter #(
    .FLIT_WIDTH  (FW),
    .PACKET_FLITS(PF),
    .BUFFER_DEPTH(BD)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .packet_din          (packet_din),
    .packet_valid_din    (packet_valid_din),
    .packet_ready_dout   (packet_ready_dout),
    .flit_dout           (flit_dout),
    .flit_valid_dout     (flit_valid_dout),
    .credit_din          (credit_din),
    .credit_count_dout   (credit_count_dout),
    .busy_dout           (busy_dout),
    .credit_overflow_dout(credit_overflow_dout),
    .packet_count_dout   (packet_count_dout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    packet_din = pkt_a;
    packet_valid_din = 1'b1;
    step();
    packet_valid_din = 1'b0;
    step();
    step();
    checks++;
    if (flit_valid_dout !== 1'b1) begin
      errors++; $display("FAIL reset_pre_valid: got %b expected 1", flit_valid_dout);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (flit_valid_dout !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", flit_valid_dout);
    end
    checks++;
    if (credit_count_dout !== 4'd8) begin
      errors++; $display("FAIL reset_credits: got %0d expected 8", credit_count_dout);
    end
    checks++;
    if (packet_ready_dout !== 1'b1 || busy_dout !== 1'b0) begin
      errors++; $display("FAIL reset_ready_busy: got %b%b expected 10", packet_ready_dout, busy_dout);
    end
    checks++;
    if (packet_count_dout !== 32'd0 || credit_overflow_dout !== 1'b0) begin
      errors++; $display("FAIL reset_count_ovf: got %0d/%b expected 0/0", packet_count_dout, credit_overflow_dout);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_packet();
    packet_din = pkt_a;
    packet_valid_din = 1'b1;
    step();
    packet_valid_din = 1'b0;
    checks++;
    if (flit_valid_dout !== 1'b0 || busy_dout !== 1'b1 || packet_ready_dout !== 1'b0) begin
      errors++; $display("FAIL single_accept: got v=%b busy=%b rdy=%b expected 0 1 0",
                         flit_valid_dout, busy_dout, packet_ready_dout);
    end
    for (int k = 0; k < PF; k++) begin
      step();
      checks++;
      if (flit_valid_dout !== 1'b1 || flit_dout !== flits_a[k]) begin
        errors++; $display("FAIL single_flit%0d: got v=%b %h expected v=1 %h", k, flit_valid_dout, flit_dout, flits_a[k]);
      end
      checks++;
      if (credit_count_dout !== CW'(BD - k - 1)) begin
        errors++; $display("FAIL single_credit%0d: got %0d expected %0d", k, credit_count_dout, BD - k - 1);
      end
    end
    checks++;
    if (packet_count_dout !== 32'd1 || busy_dout !== 1'b0 || packet_ready_dout !== 1'b1) begin
      errors++; $display("FAIL single_done: got cnt=%0d busy=%b rdy=%b expected 1 0 1",
                         packet_count_dout, busy_dout, packet_ready_dout);
    end
    step();
    checks++;
    if (flit_valid_dout !== 1'b0 || flit_dout !== flits_a[4] || credit_count_dout !== 4'd3) begin
      errors++; $display("FAIL single_after: got v=%b %h cr=%0d expected v=0 %h cr=3",
                         flit_valid_dout, flit_dout, credit_count_dout, flits_a[4]);
    end
  endtask

  task automatic test_back_to_back_starvation();
    do_reset();
    packet_din = pkt_a;
    packet_valid_din = 1'b1;
    step();
    packet_valid_din = 1'b0;
    for (int k = 0; k < PF; k++) begin
      step();
      checks++;
      if (flit_valid_dout !== 1'b1 || flit_dout !== flits_a[k]) begin
        errors++; $display("FAIL b2b_a_flit%0d: got v=%b %h expected v=1 %h", k, flit_valid_dout, flit_dout, flits_a[k]);
      end
    end
    packet_din = pkt_b;
    packet_valid_din = 1'b1;
    step();
    packet_valid_din = 1'b0;
    checks++;
    if (flit_valid_dout !== 1'b0 || busy_dout !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: got v=%b busy=%b expected v=0 busy=1", flit_valid_dout, busy_dout);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (flit_valid_dout !== 1'b1 || flit_dout !== flits_b[k] || credit_count_dout !== CW'(2 - k)) begin
        errors++; $display("FAIL starve_b_flit%0d: got v=%b %h cr=%0d expected v=1 %h cr=%0d",
                           k, flit_valid_dout, flit_dout, credit_count_dout, flits_b[k], 2 - k);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (flit_valid_dout !== 1'b0 || busy_dout !== 1'b1 || credit_count_dout !== 4'd0) begin
        errors++; $display("FAIL starve_stall%0d: got v=%b busy=%b cr=%0d expected v=0 busy=1 cr=0",
                           k, flit_valid_dout, busy_dout, credit_count_dout);
      end
    end
    credit_din = 1'b1;
    step();
    checks++;
    if (flit_valid_dout !== 1'b0 || credit_count_dout !== 4'd1) begin
      errors++; $display("FAIL starve_credit1: got v=%b cr=%0d expected v=0 cr=1", flit_valid_dout, credit_count_dout);
    end
    for (int k = 3; k < PF; k++) begin
      step();
      checks++;
      if (flit_valid_dout !== 1'b1 || flit_dout !== flits_b[k] || credit_count_dout !== 4'd1) begin
        errors++; $display("FAIL starve_resume%0d: got v=%b %h cr=%0d expected v=1 %h cr=1",
                           k, flit_valid_dout, flit_dout, credit_count_dout, flits_b[k]);
      end
    end
    credit_din = 1'b0;
    checks++;
    if (packet_count_dout !== 32'd2 || busy_dout !== 1'b0) begin
      errors++; $display("FAIL starve_done: got cnt=%0d busy=%b expected 2 0", packet_count_dout, busy_dout);
    end
    step();
    checks++;
    if (flit_valid_dout !== 1'b0 || credit_count_dout !== 4'd1) begin
      errors++; $display("FAIL starve_end: got v=%b cr=%0d expected v=0 cr=1", flit_valid_dout, credit_count_dout);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    packet_din = pkt_b;
    packet_valid_din = 1'b1;
    step();
    packet_valid_din = 1'b0;
    credit_din = 1'b1;
    for (int k = 0; k < PF; k++) begin
      step();
      checks++;
      if (flit_valid_dout !== 1'b1 || flit_dout !== flits_b[k] || credit_count_dout !== 4'd8) begin
        errors++; $display("FAIL simul_flit%0d: got v=%b %h cr=%0d expected v=1 %h cr=8",
                           k, flit_valid_dout, flit_dout, credit_count_dout, flits_b[k]);
      end
    end
    credit_din = 1'b0;
    step();
    checks++;
    if (credit_count_dout !== 4'd8 || credit_overflow_dout !== 1'b0) begin
      errors++; $display("FAIL simul_end: got cr=%0d ovf=%b expected cr=8 ovf=0", credit_count_dout, credit_overflow_dout);
    end
  endtask

  task automatic test_overflow();
    credit_din = 1'b1;
    step();
    credit_din = 1'b0;
    checks++;
    if (credit_count_dout !== 4'd8 || credit_overflow_dout !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got cr=%0d ovf=%b expected cr=8 ovf=1", credit_count_dout, credit_overflow_dout);
    end
    step();
    step();
    step();
    checks++;
    if (credit_count_dout !== 4'd8 || credit_overflow_dout !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got cr=%0d ovf=%b expected cr=8 ovf=1", credit_count_dout, credit_overflow_dout);
    end
  endtask

  task automatic test_reset_mid_packet();
    packet_din = pkt_b;
    packet_valid_din = 1'b1;
    step();
    packet_valid_din = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (flit_valid_dout !== 1'b1 || flit_dout !== flits_b[k]) begin
        errors++; $display("FAIL midrst_flit%0d: got v=%b %h expected v=1 %h", k, flit_valid_dout, flit_dout, flits_b[k]);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (flit_valid_dout !== 1'b0 || credit_overflow_dout !== 1'b0 || credit_count_dout !== 4'd8) begin
      errors++; $display("FAIL midrst_now: got v=%b ovf=%b cr=%0d expected v=0 ovf=0 cr=8",
                         flit_valid_dout, credit_overflow_dout, credit_count_dout);
    end
    step();
    step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (flit_valid_dout !== 1'b0 || busy_dout !== 1'b0 || credit_count_dout !== 4'd8) begin
        errors++; $display("FAIL midrst_quiet%0d: got v=%b busy=%b cr=%0d expected v=0 busy=0 cr=8",
                           k, flit_valid_dout, busy_dout, credit_count_dout);
      end
    end
    packet_din = pkt_a;
    packet_valid_din = 1'b1;
    step();
    packet_valid_din = 1'b0;
    for (int k = 0; k < PF; k++) begin
      step();
      checks++;
      if (flit_valid_dout !== 1'b1 || flit_dout !== flits_a[k] || credit_count_dout !== CW'(BD - k - 1)) begin
        errors++; $display("FAIL midrst_new%0d: got v=%b %h cr=%0d expected v=1 %h cr=%0d",
                           k, flit_valid_dout, flit_dout, credit_count_dout, flits_a[k], BD - k - 1);
      end
    end
    checks++;
    if (packet_count_dout !== 32'd1) begin
      errors++; $display("FAIL midrst_count: got %0d expected 1", packet_count_dout);
    end
  endtask

  initial begin
    flits_a[0] = 32'h8A59_2D2D;
    flits_a[1] = 32'hAAAA_0001;
    flits_a[2] = 32'hBBBB_0002;
    flits_a[3] = 32'hCCCC_0003;
    flits_a[4] = 32'hDDDD_0004;
    flits_b[0] = 32'h8C3F_0042;
    flits_b[1] = 32'h1234_5678;
    flits_b[2] = 32'h9ABC_DEF0;
    flits_b[3] = 32'h0F0F_F0F0;
    flits_b[4] = 32'hFFFF_0000;
    for (int k = 0; k < PF; k++) begin
      pkt_a[k*FW +: FW] = flits_a[k];
      pkt_b[k*FW +: FW] = flits_b[k];
    end

    step();
    step();
    reset = 1'b1;
    step();

    test_reset();
    test_single_packet();
    test_back_to_back_starvation();
    test_simultaneous();
    test_overflow();
    test_reset_mid_packet();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
